// File: rtl/babbage_seq_if.sv
// Handshake bundle between the button/host side and the babbage_seq sequencer.
// The master drives the two button levels; the slave returns the value and status.
interface babbage_seq_if;
    logic       start;
    logic       nextn;
    logic [9:0] outdata;
    logic [7:0] n_idx;
    logic       busy;
    logic       valid;
    logic       ovf;

    modport master (
        output start, nextn,
        input  outdata, n_idx, busy, valid, ovf
    );

    modport slave (
        input  start, nextn,
        output outdata, n_idx, busy, valid, ovf
    );
endinterface

// File: rtl/babbage_seq.sv
// Difference-engine sequencer: evaluates f(n)=A*n^2+B*n+C by finite differences,
// advancing n once per synchronised nextn edge and flagging results above 999.
module babbage_seq #(
    parameter int unsigned COEF_A = 1,
    parameter int unsigned COEF_B = 1,
    parameter int unsigned COEF_C = 41
) (
    input  logic          clk,
    input  logic          rst,
    babbage_seq_if.slave  bus
);
    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        READY,
        STEP_F,
        STEP_D,
        OVF
    } state_t;

    localparam logic [9:0]  F_INIT  = 10'(COEF_C);
    localparam logic [11:0] D1_INIT = 12'(COEF_A + COEF_B);
    localparam logic [11:0] D2_INIT = 12'(2 * COEF_A);
    localparam logic [12:0] F_MAX   = 13'd999;

    state_t      state;
    logic [9:0]  f;
    logic [11:0] d1;
    logic [11:0] d2;
    logic [7:0]  n;

    // Two synchroniser stages plus one history flop per button.
    logic start_s1, start_s2, start_h;
    logic nextn_s1, nextn_s2, nextn_h;
    logic start_p, nextn_p;
    logic [12:0] sum;

    assign start_p = start_s2 & ~start_h;
    assign nextn_p = nextn_s2 & ~nextn_h;
    assign sum     = {3'b000, f} + {1'b0, d1};

    // NOTE: every register here uses <= so all flops sample the same pre-edge
    // values; blocking assignments would make the result depend on statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            start_s1    <= 1'b0;
            start_s2    <= 1'b0;
            start_h     <= 1'b0;
            nextn_s1    <= 1'b0;
            nextn_s2    <= 1'b0;
            nextn_h     <= 1'b0;
            state       <= IDLE;
            f           <= '0;
            d1          <= '0;
            d2          <= '0;
            n           <= '0;
            bus.outdata <= '0;
            bus.n_idx   <= '0;
            bus.busy    <= 1'b0;
            bus.valid   <= 1'b0;
            bus.ovf     <= 1'b0;
        end else begin
            start_s1 <= bus.start;
            start_s2 <= start_s1;
            start_h  <= start_s2;
            nextn_s1 <= bus.nextn;
            nextn_s2 <= nextn_s1;
            nextn_h  <= nextn_s2;

            // Pulses seen in LOAD/STEP_F/STEP_D fall through unhandled: dropped, not queued.
            case (state)
                IDLE: begin
                    if (start_p) state <= LOAD;
                end
                LOAD: begin
                    f     <= F_INIT;
                    d1    <= D1_INIT;
                    d2    <= D2_INIT;
                    n     <= '0;
                    state <= READY;
                end
                READY: begin
                    if (start_p)      state <= LOAD;
                    else if (nextn_p) state <= STEP_F;
                end
                STEP_F: begin
                    if (sum > F_MAX) begin
                        state <= OVF;
                    end else begin
                        f     <= sum[9:0];
                        state <= STEP_D;
                    end
                end
                STEP_D: begin
                    d1    <= d1 + d2;
                    n     <= n + 8'd1;
                    state <= READY;
                end
                OVF: begin
                    if (start_p) state <= LOAD;
                end
                default: state <= IDLE;
            endcase

            // Outputs are decoded from the pre-edge state, one cycle behind it.
            bus.outdata <= f;
            bus.n_idx   <= n;
            bus.busy    <= (state == LOAD) || (state == STEP_F) || (state == STEP_D);
            bus.valid   <= (state == READY) || (state == OVF);
            bus.ovf     <= (state == OVF);
        end
    end
endmodule

// File: tb/tb_babbage_seq.sv
// Self-checking bench for babbage_seq: directed scenarios followed by random
// button activity, compared against a closed-form f(n) reference model.
module tb_babbage_seq;
    localparam int unsigned A = 1;
    localparam int unsigned B = 1;
    localparam int unsigned C = 41;

    logic clk;
    logic rst;
    int   tests;
    int   failed;
    int   op_id;

    // Reference model: what the host should observe once the engine is idle.
    bit m_loaded;
    bit m_ovf;
    int m_n;

    babbage_seq_if bus ();

    babbage_seq #(
        .COEF_A (A),
        .COEF_B (B),
        .COEF_C (C)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int fval(input int nn);
        return A * nn * nn + B * nn + C;
    endfunction

    task automatic check(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp)
        else begin
            failed++;
            $error("FAIL %s (op %0d): observed %0d expected %0d", tag, op_id, obs, exp);
        end
    endtask

    task automatic check_outputs();
        check("outdata", int'(bus.outdata), m_loaded ? fval(m_n) : 0);
        check("n_idx",   int'(bus.n_idx),   m_loaded ? m_n : 0);
        check("valid",   int'(bus.valid),   int'(m_loaded));
        check("ovf",     int'(bus.ovf),     int'(m_ovf));
        check("busy",    int'(bus.busy),    0);
    endtask

    // Press the selected buttons for 'hold' cycles, count busy cycles over a
    // bounded window, update the model and check the settled outputs.
    task automatic do_op(input bit s, input bit nx, input int hold);
        int busy_cnt;
        int exp_busy;
        op_id++;
        exp_busy = 0;
        if (s) begin
            m_loaded = 1'b1;
            m_ovf    = 1'b0;
            m_n      = 0;
            exp_busy = 1;
        end else if (nx && m_loaded && !m_ovf) begin
            if (fval(m_n + 1) > 999) begin
                m_ovf    = 1'b1;
                exp_busy = 1;
            end else begin
                m_n      = (m_n + 1) % 256;
                exp_busy = 2;
            end
        end
        busy_cnt = 0;
        @(negedge clk);
        bus.start = s;
        bus.nextn = nx;
        for (int i = 0; i < hold + 10; i++) begin
            @(negedge clk);
            if (i == hold - 1) begin
                bus.start = 1'b0;
                bus.nextn = 1'b0;
            end
            if (bus.busy) busy_cnt++;
        end
        check("busy_cycles", busy_cnt, exp_busy);
        check_outputs();
    endtask

    initial begin
        int busy_cnt;
        int r;
        tests     = 0;
        failed    = 0;
        op_id     = 0;
        m_loaded  = 1'b0;
        m_ovf     = 1'b0;
        m_n       = 0;
        rst       = 1'b0;
        bus.start = 1'b0;
        bus.nextn = 1'b0;

        // Reset values, during and after reset; nextn ignored in IDLE.
        repeat (2) @(negedge clk);
        check_outputs();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_outputs();
        do_op(1'b0, 1'b1, 2);

        // Load f(0), then three single steps.
        do_op(1'b1, 1'b0, 2);
        for (int k = 0; k < 3; k++) do_op(1'b0, 1'b1, 1);

        // Run up to the largest in-range value, then overflow and hold.
        while (fval(m_n + 1) <= 999) do_op(1'b0, 1'b1, 1);
        do_op(1'b0, 1'b1, 1);
        do_op(1'b0, 1'b1, 3);
        do_op(1'b0, 1'b1, 1);
        do_op(1'b1, 1'b0, 1);

        // Simultaneous start and nextn in READY: reload wins.
        do_op(1'b0, 1'b1, 1);
        do_op(1'b0, 1'b1, 1);
        do_op(1'b1, 1'b1, 2);

        // Long nextn level produces a single step.
        do_op(1'b0, 1'b1, 100);

        // Start pulse landing while the step is in progress is dropped.
        op_id++;
        busy_cnt = 0;
        for (int i = 0; i < 14; i++) begin
            bus.nextn = (i < 3);
            bus.start = (i == 1);
            @(negedge clk);
            if (bus.busy) busy_cnt++;
        end
        m_n = m_n + 1;
        check("busy_cycles_start_dropped", busy_cnt, 2);
        check_outputs();

        // Reset asserted while STEP_F is in progress.
        op_id++;
        bus.nextn = 1'b1;
        repeat (3) @(negedge clk);
        bus.nextn = 1'b0;
        rst = 1'b0;
        #1;
        m_loaded = 1'b0;
        m_ovf    = 1'b0;
        m_n      = 0;
        check_outputs();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_outputs();
        do_op(1'b0, 1'b1, 1);

        // Random button activity.
        do_op(1'b1, 1'b0, 1);
        for (int k = 0; k < 60; k++) begin
            r = int'($urandom_range(0, 9));
            do_op(r == 0 || r == 1, r != 0, int'($urandom_range(1, 4)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
